// File: rtl/vid_timing_pkg.sv
// Shared defaults (720p timing), FSM state type and colour helpers for vid_timing_gen.
package vid_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 1280;
    localparam int unsigned DEF_H_FP     = 110;
    localparam int unsigned DEF_H_SYNC   = 40;
    localparam int unsigned DEF_H_BP     = 220;
    localparam int unsigned DEF_V_ACTIVE = 720;
    localparam int unsigned DEF_V_FP     = 5;
    localparam int unsigned DEF_V_SYNC   = 5;
    localparam int unsigned DEF_V_BP     = 20;
    localparam int unsigned DEF_CTR_W    = 12;

    localparam logic [23:0] DEF_UNDERRUN_RGB = 24'h000000;

    localparam logic [7:0] COMP_ON  = 8'hFF;
    localparam logic [7:0] COMP_OFF = 8'h00;

    typedef enum logic {
        StIdle,
        StRun
    } vt_state_e;

    function automatic logic [23:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b);
        return {r, g, b};
    endfunction

    // Bars: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        return pack_rgb(idx[1] ? COMP_OFF : COMP_ON,
                        idx[2] ? COMP_OFF : COMP_ON,
                        idx[0] ? COMP_OFF : COMP_ON);
    endfunction

endpackage

// File: rtl/vid_axis_counter.sv
// Wrapping raster-axis counter with terminal count, active-region and sync-window decode.
module vid_axis_counter #(
    parameter int unsigned CntW   = 12,
    parameter int unsigned Total  = 1650,
    parameter int unsigned Active = 1280,
    parameter int unsigned WinLo  = 1390,
    parameter int unsigned WinHi  = 1430
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [CntW-1:0] cnt_o,
    output logic            tc_o,
    output logic            act_o,
    output logic            win_o
);

    logic [CntW-1:0] cnt_q, cnt_d;
    int unsigned     cnt_w;

    // Compare at 32 bits so a window edge equal to 2^CntW cannot alias to zero.
    always_comb begin
        cnt_w = 32'(cnt_q);
        tc_o  = (cnt_w == Total - 1);
        act_o = (cnt_w < Active);
        win_o = (cnt_w >= WinLo) && (cnt_w < WinHi);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vid_timing_gen.sv
// Raster timing generator feeding the TMDS encoder; colour-bar test pattern is built in
// only when VID_TIMING_TEST_PATTERN_EN is defined.
module vid_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned H_FP         = DEF_H_FP,
    parameter int unsigned H_SYNC       = DEF_H_SYNC,
    parameter int unsigned H_BP         = DEF_H_BP,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned V_FP         = DEF_V_FP,
    parameter int unsigned V_SYNC       = DEF_V_SYNC,
    parameter int unsigned V_BP         = DEF_V_BP,
    parameter bit          HSYNC_POL    = 1'b1,
    parameter bit          VSYNC_POL    = 1'b1,
    parameter int unsigned CTR_W        = DEF_CTR_W,
    parameter logic [23:0] UNDERRUN_RGB = DEF_UNDERRUN_RGB
) (
    input  logic             vga_clk_sig,
    input  logic             reset,
    input  logic             enable,
`ifdef VID_TIMING_TEST_PATTERN_EN
    input  logic             test_pattern,
`endif
    input  logic [23:0]      pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             dvi_de,
    output logic [7:0]       dvi_red,
    output logic [7:0]       dvi_grn,
    output logic [7:0]       dvi_blu,
    output logic             dvi_hsync,
    output logic             dvi_vsync,
    output logic [3:0]       dvi_ctl,
    output logic             frame_start,
    output logic             underrun,
    output logic [15:0]      underrun_cnt,
    output logic [CTR_W-1:0] h_cnt,
    output logic [CTR_W-1:0] v_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    vt_state_e   state_q, state_d;
    logic        run, active, cnt_clr, und_pix, frame_first, tp_on;
    logic        h_tc, h_act, h_win, v_tc, v_act, v_win;
    logic [23:0] bar_colour;

    logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, und_q, und_d;
    logic [23:0] rgb_q, rgb_d;
    logic [15:0] ucnt_q, ucnt_d;

    vid_axis_counter #(
        .CntW  (CTR_W),
        .Total (H_TOTAL),
        .Active(H_ACTIVE),
        .WinLo (H_ACTIVE + H_FP),
        .WinHi (H_ACTIVE + H_FP + H_SYNC)
    ) u_h_axis (
        .clk_i (vga_clk_sig),
        .rst_ni(reset),
        .clr_i (cnt_clr),
        .inc_i (1'b1),
        .cnt_o (h_cnt),
        .tc_o  (h_tc),
        .act_o (h_act),
        .win_o (h_win)
    );

    vid_axis_counter #(
        .CntW  (CTR_W),
        .Total (V_TOTAL),
        .Active(V_ACTIVE),
        .WinLo (V_ACTIVE + V_FP),
        .WinHi (V_ACTIVE + V_FP + V_SYNC)
    ) u_v_axis (
        .clk_i (vga_clk_sig),
        .rst_ni(reset),
        .clr_i (cnt_clr),
        .inc_i (h_tc),
        .cnt_o (v_cnt),
        .tc_o  (v_tc),
        .act_o (v_act),
        .win_o (v_win)
    );

`ifdef VID_TIMING_TEST_PATTERN_EN
    localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    logic [2:0] bar_idx;
    assign tp_on      = test_pattern;
    assign bar_idx    = 3'(h_cnt / CTR_W'(BAR_W));
    assign bar_colour = bar_rgb(bar_idx);
`else
    assign tp_on      = 1'b0;
    assign bar_colour = '0;
`endif

    always_ff @(posedge vga_clk_sig) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // enable is only honoured on a frame boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (enable) state_d = StRun;
            StRun:   if (h_tc && v_tc && !enable) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        run         = (state_q == StRun);
        cnt_clr     = !run;
        active      = run && h_act && v_act;
        pix_ready   = active && !tp_on;
        und_pix     = active && !pix_valid && !tp_on;
        frame_first = run && (h_cnt == '0) && (v_cnt == '0);

        de_d  = active;
        rgb_d = '0;
        if (active) begin
            if (tp_on) begin
                rgb_d = bar_colour;
            end else if (pix_valid) begin
                rgb_d = pix_data;
            end else begin
                rgb_d = UNDERRUN_RGB;
            end
        end
        hs_d  = (run && h_win) ? HSYNC_POL : !HSYNC_POL;
        vs_d  = (run && v_win) ? VSYNC_POL : !VSYNC_POL;
        fs_d  = frame_first;
        und_d = und_q | und_pix;

        ucnt_d = ucnt_q;
        if (frame_first && !tp_on) begin
            ucnt_d = und_pix ? 16'd1 : 16'd0;
        end else if (und_pix && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge vga_clk_sig) begin
        if (!reset) begin
            de_q   <= 1'b0;
            rgb_q  <= '0;
            hs_q   <= !HSYNC_POL;
            vs_q   <= !VSYNC_POL;
            fs_q   <= 1'b0;
            und_q  <= 1'b0;
            ucnt_q <= '0;
        end else begin
            de_q   <= de_d;
            rgb_q  <= rgb_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            fs_q   <= fs_d;
            und_q  <= und_d;
            ucnt_q <= ucnt_d;
        end
    end

    assign dvi_de       = de_q;
    assign dvi_red      = rgb_q[23:16];
    assign dvi_grn      = rgb_q[15:8];
    assign dvi_blu      = rgb_q[7:0];
    assign dvi_hsync    = hs_q;
    assign dvi_vsync    = vs_q;
    assign dvi_ctl      = 4'b0000;
    assign frame_start  = fs_q;
    assign underrun     = und_q;
    assign underrun_cnt = ucnt_q;

endmodule
